// File: rtl/uart_axi_pkg.sv
// Shared constants and FSM state types for the AXI-attached buffered UART.
package uart_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int STAT_TXNF   = 0;
    localparam int STAT_RXAV   = 1;
    localparam int STAT_TXIDLE = 2;
    localparam int STAT_OVR    = 3;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_e;

    typedef enum logic [1:0] {
        W_COLLECT,
        W_EXEC,
        W_RESP
    } wr_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_axi_fifo_fifo.sv
// Synchronous FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rptr_q];

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wptr_d  = wptr_q + AW'(do_push);
        rptr_d  = rptr_q + AW'(do_pop);
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/uart_axi_fifo.sv
// AXI4 single-beat slave owning a FIFO-buffered 8N1 UART transmitter and receiver.
module uart_axi_fifo
    import uart_axi_pkg::*;
#(
    parameter int          CLK_FREQ  = 150000000,
    parameter int          UART_BAUD = 9600,
    parameter int          TX_DEPTH  = 16,
    parameter int          RX_DEPTH  = 16,
    parameter logic [31:0] DATA_ADDR = 32'hBFD003F8,
    parameter logic [31:0] STAT_ADDR = 32'hBFD003FC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        txd,
    input  logic        rxd,
    input  logic [7:0]  io_uart_ar_id,
    input  logic [31:0] io_uart_ar_addr,
    input  logic        io_uart_ar_valid,
    output logic        io_uart_ar_ready,
    output logic [7:0]  io_uart_r_id,
    output logic [31:0] io_uart_r_data,
    output logic [1:0]  io_uart_r_resp,
    output logic        io_uart_r_last,
    output logic        io_uart_r_valid,
    input  logic        io_uart_r_ready,
    input  logic [7:0]  io_uart_aw_id,
    input  logic [31:0] io_uart_aw_addr,
    input  logic        io_uart_aw_valid,
    output logic        io_uart_aw_ready,
    input  logic [31:0] io_uart_w_data,
    input  logic [3:0]  io_uart_w_strb,
    input  logic        io_uart_w_valid,
    output logic        io_uart_w_ready,
    output logic [7:0]  io_uart_b_id,
    output logic [1:0]  io_uart_b_resp,
    output logic        io_uart_b_valid,
    input  logic        io_uart_b_ready
);
    localparam int DIV = CLK_FREQ / UART_BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int TXC = $clog2(TX_DEPTH) + 1;
    localparam int RXC = $clog2(RX_DEPTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

    logic           tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]     tx_dout;
    logic [TXC-1:0] tx_count;
    logic           rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]     rx_dout;
    logic [RXC-1:0] rx_count;

    rd_state_e   rd_q, rd_d;
    logic [7:0]  r_id_q, r_id_d;
    logic [31:0] r_data_q, r_data_d;
    logic [1:0]  r_resp_q, r_resp_d;
    logic [31:0] stat;
    logic        ovr_clr;

    wr_state_e   wr_q, wr_d;
    logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic [7:0]  aw_id_q, aw_id_d;
    logic [7:0]  w_byte_q, w_byte_d;
    logic        w_strb_q, w_strb_d;
    logic [7:0]  b_id_q, b_id_d;
    logic [1:0]  b_resp_q, b_resp_d;

    tx_state_e   tx_q, tx_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        txd_q, txd_d, tx_tick;

    rx_state_e   rx_q, rx_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
    logic        rx_prev_q, rx_prev_d, rx_tick;
    logic        ovr_q, ovr_d;

    logic        unused_bits;
    assign unused_bits = ^{io_uart_w_data[31:8], io_uart_w_strb[3:1]};

    uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop),
        .din(w_byte_q), .dout(tx_dout), .full(tx_full),
        .empty(tx_empty), .count(tx_count)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop),
        .din(rx_sh_q), .dout(rx_dout), .full(rx_full),
        .empty(rx_empty), .count(rx_count)
    );

    assign txd              = txd_q;
    assign io_uart_ar_ready = (rd_q == R_IDLE);
    assign io_uart_r_valid  = (rd_q == R_RESP);
    assign io_uart_r_id     = r_id_q;
    assign io_uart_r_data   = r_data_q;
    assign io_uart_r_resp   = r_resp_q;
    assign io_uart_r_last   = 1'b1;
    assign io_uart_aw_ready = (wr_q == W_COLLECT) && !aw_held_q;
    assign io_uart_w_ready  = (wr_q == W_COLLECT) && !w_held_q;
    assign io_uart_b_valid  = (wr_q == W_RESP);
    assign io_uart_b_id     = b_id_q;
    assign io_uart_b_resp   = b_resp_q;

    always_comb begin
        stat              = '0;
        stat[STAT_TXNF]   = !tx_full;
        stat[STAT_RXAV]   = (rx_count != '0);
        stat[STAT_TXIDLE] = (tx_count == '0) && (tx_q == TX_IDLE);
        stat[STAT_OVR]    = ovr_q;
    end

    always_comb begin
        rd_d     = rd_q;
        r_id_d   = r_id_q;
        r_data_d = r_data_q;
        r_resp_d = r_resp_q;
        rx_pop   = 1'b0;
        ovr_clr  = 1'b0;
        unique case (rd_q)
            R_IDLE: begin
                if (io_uart_ar_valid) begin
                    rd_d     = R_RESP;
                    r_id_d   = io_uart_ar_id;
                    r_data_d = '0;
                    r_resp_d = RESP_OKAY;
                    if (io_uart_ar_addr == DATA_ADDR) begin
                        rx_pop   = !rx_empty;
                        r_data_d = rx_empty ? '0 : {24'b0, rx_dout};
                    end else if (io_uart_ar_addr == STAT_ADDR) begin
                        r_data_d = stat;
                        ovr_clr  = 1'b1;
                    end else begin
                        r_resp_d = RESP_SLVERR;
                    end
                end
            end
            R_RESP: if (io_uart_r_ready) rd_d = R_IDLE;
        endcase
    end

    always_comb begin
        wr_d      = wr_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_addr_d = aw_addr_q;
        aw_id_d   = aw_id_q;
        w_byte_d  = w_byte_q;
        w_strb_d  = w_strb_q;
        b_id_d    = b_id_q;
        b_resp_d  = b_resp_q;
        tx_push   = 1'b0;
        unique case (wr_q)
            W_COLLECT: begin
                if (io_uart_aw_ready && io_uart_aw_valid) begin
                    aw_held_d = 1'b1;
                    aw_addr_d = io_uart_aw_addr;
                    aw_id_d   = io_uart_aw_id;
                end
                if (io_uart_w_ready && io_uart_w_valid) begin
                    w_held_d = 1'b1;
                    w_byte_d = io_uart_w_data[7:0];
                    w_strb_d = io_uart_w_strb[0];
                end
                if (aw_held_q && w_held_q) wr_d = W_EXEC;
            end
            W_EXEC: begin
                b_id_d   = aw_id_q;
                b_resp_d = RESP_OKAY;
                if (aw_addr_q == DATA_ADDR && w_strb_q) begin
                    // stall rather than drop when the TX FIFO is full
                    if (!tx_full || tx_pop) begin
                        tx_push = 1'b1;
                        wr_d    = W_RESP;
                    end
                end else begin
                    wr_d = W_RESP;
                    if (aw_addr_q != DATA_ADDR && aw_addr_q != STAT_ADDR)
                        b_resp_d = RESP_SLVERR;
                end
            end
            W_RESP: begin
                if (io_uart_b_ready) begin
                    wr_d      = W_COLLECT;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
            default: wr_d = W_COLLECT;
        endcase
    end

    always_comb begin
        tx_d     = tx_q;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        txd_d    = txd_q;
        tx_pop   = 1'b0;
        tx_tick  = (tx_cnt_q == LAST);
        tx_cnt_d = tx_tick ? '0 : tx_cnt_q + 1'b1;
        unique case (tx_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                txd_d    = 1'b1;
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_d     = TX_DATA;
                    tx_bit_d = '0;
                    txd_d    = tx_sh_q[0];
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    if (tx_bit_q == 3'd7) begin
                        tx_d  = TX_STOP;
                        txd_d = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                        txd_d    = tx_sh_q[1];
                    end
                end
            end
            TX_STOP: if (tx_tick) tx_d = TX_IDLE;
        endcase
        // next byte starts straight out of the stop bit when one is queued
        if ((tx_q == TX_IDLE || (tx_q == TX_STOP && tx_tick)) && !tx_empty) begin
            tx_pop   = 1'b1;
            tx_sh_d  = tx_dout;
            tx_d     = TX_START;
            tx_cnt_d = '0;
            txd_d    = 1'b0;
        end
    end

    always_comb begin
        rx_s1_d   = rxd;
        rx_s2_d   = rx_s1_q;
        rx_prev_d = rx_s2_q;
        rx_d      = rx_q;
        rx_bit_d  = rx_bit_q;
        rx_sh_d   = rx_sh_q;
        rx_push   = 1'b0;
        rx_tick   = (rx_cnt_q == LAST);
        rx_cnt_d  = rx_cnt_q + 1'b1;
        unique case (rx_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) rx_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == HALF) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_d     = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_d = RX_STOP;
                    else rx_bit_d = rx_bit_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    rx_cnt_d = '0;
                    rx_d     = RX_IDLE;
                    rx_push  = rx_s2_q;
                end
            end
        endcase
        ovr_d = ovr_clr ? 1'b0 : ovr_q;
        if (rx_push && rx_full && !rx_pop) ovr_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q     <= R_IDLE;
            r_id_q   <= '0;
            r_data_q <= '0;
            r_resp_q <= RESP_OKAY;
        end else begin
            rd_q     <= rd_d;
            r_id_q   <= r_id_d;
            r_data_q <= r_data_d;
            r_resp_q <= r_resp_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q      <= W_COLLECT;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            aw_id_q   <= '0;
            w_byte_q  <= '0;
            w_strb_q  <= 1'b0;
            b_id_q    <= '0;
            b_resp_q  <= RESP_OKAY;
        end else begin
            wr_q      <= wr_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_addr_q <= aw_addr_d;
            aw_id_q   <= aw_id_d;
            w_byte_q  <= w_byte_d;
            w_strb_q  <= w_strb_d;
            b_id_q    <= b_id_d;
            b_resp_q  <= b_resp_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q     <= TX_IDLE;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= '0;
            txd_q    <= 1'b1;
        end else begin
            tx_q     <= tx_d;
            tx_cnt_q <= tx_cnt_d;
            tx_bit_q <= tx_bit_d;
            tx_sh_q  <= tx_sh_d;
            txd_q    <= txd_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            rx_q      <= RX_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            ovr_q     <= 1'b0;
        end else begin
            rx_s1_q   <= rx_s1_d;
            rx_s2_q   <= rx_s2_d;
            rx_prev_q <= rx_prev_d;
            rx_q      <= rx_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            ovr_q     <= ovr_d;
        end
    end

endmodule

// File: tb/tb_uart_axi_fifo.sv
// Directed and randomized bench for uart_axi_fifo at DIV=16 with a queue-based reference model.
module tb_uart_axi_fifo;
    localparam logic [31:0] DA  = 32'hBFD003F8;
    localparam logic [31:0] SA  = 32'hBFD003FC;
    localparam logic [31:0] BAD = 32'hBFD00000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        io_uart_txd;
    logic        rxd = 1'b1;
    logic [7:0]  io_uart_ar_id = '0;
    logic [31:0] io_uart_ar_addr = '0;
    logic        io_uart_ar_valid = 1'b0;
    logic        io_uart_ar_ready;
    logic [7:0]  io_uart_r_id;
    logic [31:0] io_uart_r_data;
    logic [1:0]  io_uart_r_resp;
    logic        io_uart_r_last;
    logic        io_uart_r_valid;
    logic        io_uart_r_ready = 1'b0;
    logic [7:0]  io_uart_aw_id = '0;
    logic [31:0] io_uart_aw_addr = '0;
    logic        io_uart_aw_valid = 1'b0;
    logic        io_uart_aw_ready;
    logic [31:0] io_uart_w_data = '0;
    logic [3:0]  io_uart_w_strb = '0;
    logic        io_uart_w_valid = 1'b0;
    logic        io_uart_w_ready;
    logic [7:0]  io_uart_b_id;
    logic [1:0]  io_uart_b_resp;
    logic        io_uart_b_valid;
    logic        io_uart_b_ready = 1'b0;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [7:0] txq[$];
    int         txs[$];
    bit         txok[$];
    int         low_run = 0;

    logic [7:0] rxm[$];
    bit         ovr_m = 1'b0;

    uart_axi_fifo #(
        .CLK_FREQ(16), .UART_BAUD(1), .TX_DEPTH(16), .RX_DEPTH(16),
        .DATA_ADDR(DA), .STAT_ADDR(SA)
    ) dut (
        .clk(clk), .rst(rst), .txd(io_uart_txd), .rxd(rxd),
        .io_uart_ar_id(io_uart_ar_id), .io_uart_ar_addr(io_uart_ar_addr),
        .io_uart_ar_valid(io_uart_ar_valid), .io_uart_ar_ready(io_uart_ar_ready),
        .io_uart_r_id(io_uart_r_id), .io_uart_r_data(io_uart_r_data),
        .io_uart_r_resp(io_uart_r_resp), .io_uart_r_last(io_uart_r_last),
        .io_uart_r_valid(io_uart_r_valid), .io_uart_r_ready(io_uart_r_ready),
        .io_uart_aw_id(io_uart_aw_id), .io_uart_aw_addr(io_uart_aw_addr),
        .io_uart_aw_valid(io_uart_aw_valid), .io_uart_aw_ready(io_uart_aw_ready),
        .io_uart_w_data(io_uart_w_data), .io_uart_w_strb(io_uart_w_strb),
        .io_uart_w_valid(io_uart_w_valid), .io_uart_w_ready(io_uart_w_ready),
        .io_uart_b_id(io_uart_b_id), .io_uart_b_resp(io_uart_b_resp),
        .io_uart_b_valid(io_uart_b_valid), .io_uart_b_ready(io_uart_b_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: observed no finish, required finish before 80000 cycles");
        $fatal(1, "timeout");
    end

    // decodes every frame on txd by mid-bit sampling
    initial begin : tx_mon
        forever begin : frm
            logic [7:0] b;
            bit         ok;
            int         t;
            @(negedge io_uart_txd);
            #1;
            t = cyc;
            repeat (8) @(posedge clk);
            #2;
            ok = (io_uart_txd === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (16) @(posedge clk);
                #2;
                b[i] = io_uart_txd;
            end
            repeat (16) @(posedge clk);
            #2;
            ok = ok && (io_uart_txd === 1'b1);
            txq.push_back(b);
            txs.push_back(t);
            txok.push_back(ok);
        end
    end

    initial begin : low_mon
        forever begin : run
            int n;
            @(negedge io_uart_txd);
            n = 0;
            while (io_uart_txd === 1'b0 && n < 400) begin
                @(posedge clk);
                #2;
                n++;
            end
            low_run = n;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [7:0] id, input int hold,
                            output logic [31:0] d, output logic [1:0] resp);
        int k;
        bit hs;
        io_uart_ar_addr  = a;
        io_uart_ar_id    = id;
        io_uart_ar_valid = 1'b1;
        hs = 1'b0;
        k  = 0;
        while (!hs && k < 50) begin
            hs = io_uart_ar_ready;
            @(posedge clk);
            #1;
            k++;
        end
        io_uart_ar_valid = 1'b0;
        chk("ar_hs", hs, 1);
        chk("r_latency", io_uart_r_valid, 1);
        chk("r_id", io_uart_r_id, id);
        chk("r_last", io_uart_r_last, 1);
        d    = io_uart_r_data;
        resp = io_uart_r_resp;
        cycles(hold);
        if (hold > 0)
            chk("r_hold", {io_uart_r_valid, io_uart_r_resp, io_uart_r_data}, {1'b1, resp, d});
        io_uart_r_ready = 1'b1;
        cycles(1);
        io_uart_r_ready = 1'b0;
        chk("r_drop", io_uart_r_valid, 0);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [7:0] data, input logic strb0,
                             input logic [7:0] id, output logic [1:0] resp, output int bcyc);
        int k;
        bit aw_d, w_d, aw_hs, w_hs, hs;
        logic [7:0] bid;
        io_uart_aw_addr  = a;
        io_uart_aw_id    = id;
        io_uart_aw_valid = 1'b1;
        io_uart_w_data   = {24'h0, data};
        io_uart_w_strb   = {3'b111, strb0};
        io_uart_w_valid  = 1'b1;
        aw_d = 1'b0;
        w_d  = 1'b0;
        k    = 0;
        while (!(aw_d && w_d) && k < 50) begin
            aw_hs = io_uart_aw_valid && io_uart_aw_ready;
            w_hs  = io_uart_w_valid && io_uart_w_ready;
            @(posedge clk);
            #1;
            if (aw_hs) begin
                aw_d = 1'b1;
                io_uart_aw_valid = 1'b0;
            end
            if (w_hs) begin
                w_d = 1'b1;
                io_uart_w_valid = 1'b0;
            end
            k++;
        end
        io_uart_aw_valid = 1'b0;
        io_uart_w_valid  = 1'b0;
        chk("aw_w_hs", {aw_d, w_d}, 2'b11);
        io_uart_b_ready = 1'b1;
        hs   = 1'b0;
        resp = 2'b11;
        bid  = '0;
        k    = 0;
        while (!hs && k < 400) begin
            hs = io_uart_b_valid;
            if (hs) begin
                resp = io_uart_b_resp;
                bid  = io_uart_b_id;
            end
            @(posedge clk);
            #1;
            k++;
        end
        io_uart_b_ready = 1'b0;
        bcyc = cyc;
        chk("b_hs", hs, 1);
        chk("b_id", bid, id);
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stopb, input int idle);
        rxd = 1'b0;
        cycles(16);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            cycles(16);
        end
        rxd = stopb;
        cycles(16);
        rxd = 1'b1;
        cycles(idle);
        if (stopb) begin
            if (rxm.size() < 16) rxm.push_back(b);
            else ovr_m = 1'b1;
        end
    endtask

    task automatic wait_tx(input int n, input int lim);
        int k;
        k = 0;
        while (txq.size() < n && k < lim) begin
            cycles(1);
            k++;
        end
        chk("tx_frames", txq.size() >= n, 1);
    endtask

    function automatic logic [31:0] exp_stat();
        return {28'd0, ovr_m, 1'b1, rxm.size() != 0, 1'b1};
    endfunction

    task automatic rd_stat(input string tag);
        logic [31:0] d, e;
        logic [1:0] rs;
        e = exp_stat();
        axi_read(SA, 8'h51, 0, d, rs);
        chk(tag, {rs, d}, {2'b00, e});
        ovr_m = 1'b0;
    endtask

    task automatic rd_data(input string tag);
        logic [31:0] d, e;
        logic [1:0] rs;
        e = (rxm.size() != 0) ? {24'd0, rxm.pop_front()} : 32'd0;
        axi_read(DA, 8'hD4, 0, d, rs);
        chk(tag, {rs, d}, {2'b00, e});
    endtask

    initial begin : main
        logic [31:0] d;
        logic [1:0]  rs;
        int          bc, t0, lowc;
        int          lat[18];
        logic [7:0]  eb[$];

        cycles(3);
        chk("rst_ready", {io_uart_ar_ready, io_uart_aw_ready, io_uart_w_ready}, 3'b111);
        chk("rst_valid", {io_uart_r_valid, io_uart_b_valid}, 2'b00);
        chk("rst_txd", io_uart_txd, 1);
        chk("rst_payload", {io_uart_r_id, io_uart_r_data, io_uart_r_resp,
                            io_uart_b_id, io_uart_b_resp}, 52'd0);
        rst = 1'b0;
        cycles(2);
        rd_stat("rst_stat");

        // 1: single TX byte
        axi_write(DA, 8'h55, 1'b1, 8'h3A, rs, bc);
        chk("t1_bresp", rs, 2'b00);
        wait_tx(1, 400);
        cycles(20);
        chk("t1_byte", txq[0], 8'h55);
        chk("t1_frame", txok[0], 1);
        chk("t1_start_len", low_run, 16);
        txq.delete();
        txs.delete();
        txok.delete();

        // 2: single RX byte, with a stalled R to check payload hold
        send_rx(8'hA5, 1'b1, 8);
        rd_stat("t2_stat_full");
        e_hold_read(d, rs);
        chk("t2_data", {rs, d}, {2'b00, 32'h000000A5});
        rxm.delete();
        rd_stat("t2_stat_empty");

        // 3: 18 back-to-back writes, the last one back-pressured
        t0 = cyc;
        for (int i = 0; i < 18; i++) begin
            eb.push_back(8'($urandom_range(0, 255)));
            axi_write(DA, eb[i], 1'b1, 8'(i), rs, bc);
            lat[i] = bc - t0;
            chk("t3_bresp", rs, 2'b00);
        end
        chk("t3_prompt17", lat[16] < 120, 1);
        chk("t3_held18", lat[17] >= 150, 1);
        wait_tx(18, 4000);
        cycles(20);
        for (int i = 0; i < 18; i++) begin
            chk("t3_byte", txq[i], eb[i]);
            chk("t3_frame", txok[i], 1);
            if (i > 0) chk("t3_gap", txs[i] - txs[i-1], 160);
        end
        txq.delete();
        txs.delete();
        txok.delete();

        // 4: RX overrun
        for (int i = 0; i < 17; i++)
            send_rx(8'($urandom_range(0, 255)), 1'b1, 0);
        cycles(8);
        chk("t4_ovr_model", ovr_m, 1);
        rd_stat("t4_stat_ovr");
        for (int i = 0; i < 16; i++) rd_data("t4_data");
        rd_stat("t4_stat_after");

        // 5: bad address
        axi_read(BAD, 8'h77, 0, d, rs);
        chk("t5_rd", {rs, d}, {2'b10, 32'd0});
        axi_write(BAD, 8'h00, 1'b1, 8'h78, rs, bc);
        chk("t5_bresp", rs, 2'b10);
        lowc = 0;
        for (int i = 0; i < 48; i++) begin
            cycles(1);
            if (io_uart_txd !== 1'b1) lowc++;
        end
        chk("t5_txd_high", lowc, 0);
        axi_write(SA, 8'hFF, 1'b1, 8'h79, rs, bc);
        chk("t5_stat_wr", rs, 2'b00);

        // 6: RX glitch, framing error, reset mid-frame
        rxd = 1'b0;
        cycles(4);
        rxd = 1'b1;
        cycles(40);
        rd_stat("t6_glitch");
        send_rx(8'h81, 1'b0, 8);
        rd_stat("t6_framing");
        send_rx(8'h3C, 1'b1, 8);
        axi_write(DA, 8'h11, 1'b1, 8'h01, rs, bc);
        axi_write(DA, 8'h22, 1'b1, 8'h02, rs, bc);
        cycles(40);
        chk("t6_txd_busy", io_uart_txd, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_txd", io_uart_txd, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rxm.delete();
        ovr_m = 1'b0;
        cycles(2);
        rd_stat("t6_stat_rst");
        rd_data("t6_rx_empty");
        lowc = 0;
        for (int i = 0; i < 200; i++) begin
            cycles(1);
            if (io_uart_txd !== 1'b1) lowc++;
        end
        chk("t6_tx_empty", lowc, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    task automatic e_hold_read(output logic [31:0] d, output logic [1:0] rs);
        axi_read(DA, 8'hC3, 3, d, rs);
    endtask

endmodule
